// File: rtl/tohost_uart.sv
// tohost_uart: decodes tohost MMIO writes, buffers putc bytes in a FIFO and sends them as 8N1 UART frames.
// Optional build macro TOHOST_CRLF_EN inserts a CR byte in front of every LF byte.
`ifndef TOHOST_ADDR
`define TOHOST_ADDR 32'h8000_1000
`endif

module tohost_uart #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = `TOHOST_ADDR,
  parameter int              FIFO_DEPTH   = 16,
  parameter int              CLKS_PER_BIT = 868
) (
  input  logic            aclk_i,
  input  logic            areset_i,
  input  logic            wvalid_i,
  input  logic [XLEN-1:0] waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            wready_o,
  output logic            uart_tx_o,
  output logic            busy_o,
  output logic            finish_o,
  output logic [15:0]     exit_code_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic          full, empty;
  logic          push, pop;
  logic [7:0]    push_data;

  state_t        state_reg, state_next;
  logic [CW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          baud_done;

  logic          exit_pend_reg, finish_reg, busy_reg;
  logic [15:0]   exit_code_reg;

  logic          hit, stopped, putc_req, exit_req;
  logic [1:0]    cmd;
  logic          unused_wdata;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign hit          = wvalid_i && (waddr_i == TOHOST_ADDR);
  assign cmd          = wdata_i[17:16];
  assign stopped      = exit_pend_reg || finish_reg;
  assign putc_req     = hit && (cmd == 2'b01) && !stopped;
  assign exit_req     = hit && (cmd == 2'b10) && !stopped && wready_o;
  assign unused_wdata = ^wdata_i[XLEN-1:18];

`ifdef TOHOST_CRLF_EN
  localparam logic [AW:0] LF_MAX_COUNT = (AW+1)'(FIFO_DEPTH - 2);

  logic        crlf_pend_reg;
  logic [AW:0] count;
  logic        is_lf, room;

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign is_lf = (wdata_i[7:0] == 8'h0A);
  // An LF needs space for both the inserted CR and itself before it is accepted.
  assign room  = is_lf ? (count <= LF_MAX_COUNT) : !full;

  assign wready_o  = !crlf_pend_reg && !(putc_req && !room);
  assign push      = crlf_pend_reg || (putc_req && room);
  assign push_data = crlf_pend_reg ? 8'h0A : (is_lf ? 8'h0D : wdata_i[7:0]);

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      crlf_pend_reg <= 1'b0;
    end else begin
      crlf_pend_reg <= !crlf_pend_reg && putc_req && room && is_lf;
    end
  end
`else
  assign wready_o  = !(putc_req && full);
  assign push      = putc_req && !full;
  assign push_data = wdata_i[7:0];
`endif

  always_ff @(posedge aclk_i) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign baud_done = (baud_reg == '0);

  // Every state entry reloads the baud counter so each bit lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg - 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = BAUD_RELOAD;
        if (!empty) begin
          state_next = START;
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg[AW-1:0]];
        end
      end
      START: begin
        if (baud_done) begin
          state_next = DATA;
          baud_next  = BAUD_RELOAD;
          bit_next   = 3'd0;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = BAUD_RELOAD;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = BAUD_RELOAD;
          if (!empty) begin
            state_next = START;
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg[AW-1:0]];
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_reg <= IDLE;
      baud_reg  <= BAUD_RELOAD;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      exit_pend_reg <= 1'b0;
      exit_code_reg <= 16'h0000;
      finish_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      if (exit_req) begin
        exit_pend_reg <= 1'b1;
        exit_code_reg <= wdata_i[15:0];
      end
      // Termination waits until the last stop bit has fully left the wire.
      if (exit_pend_reg && empty && (state_reg == IDLE)) begin
        finish_reg <= 1'b1;
      end
      busy_reg <= !empty || (state_reg != IDLE);
    end
  end

  assign uart_tx_o   = tx_reg;
  assign busy_o      = busy_reg;
  assign finish_o    = finish_reg;
  assign exit_code_o = exit_code_reg;

endmodule

// File: tb/tb_tohost_uart.sv
// Self-checking bench for tohost_uart: decodes the UART line and compares against a byte-queue model.
module tb_tohost_uart;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] ADDR  = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wvalid = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        wready, tx, busy, finish;
  logic [15:0] code;

  tohost_uart #(
    .XLEN(32), .TOHOST_ADDR(ADDR), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
  ) dut (
    .aclk_i(clk), .areset_i(rst), .wvalid_i(wvalid), .waddr_i(waddr), .wdata_i(wdata),
    .wready_o(wready), .uart_tx_o(tx), .busy_o(busy), .finish_o(finish), .exit_code_o(code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_epoch = 0;
  always @(posedge rst) rst_epoch++;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // UART receiver: samples each bit in its middle; frames cut short by reset are discarded.
  logic [7:0] rx_q[$];
  int         rx_at[$];
  int         frame_err = 0;

  initial begin : monitor
    forever begin
      int         st, ep;
      logic [7:0] b;
      logic       ok;
      @(negedge tx);
      st = cyc;
      ep = rst_epoch;
      repeat (CPB / 2) @(posedge clk);
      @(negedge clk);
      ok = (tx == 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      ok = ok && (tx == 1'b1);
      if (ep == rst_epoch && !rst) begin
        if (ok) begin
          rx_q.push_back(b);
          rx_at.push_back(st);
        end else begin
          frame_err++;
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] putc_word(input logic [7:0] b);
    logic [31:0] w;
    w = $urandom;
    w[17:16] = 2'b01;
    w[7:0]   = b;
    return w;
  endfunction

  function automatic logic [31:0] exit_word(input logic [15:0] c);
    return {14'b0, 2'b10, c};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    rx_at.delete();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int max_wait,
                          output logic acc, output int stalls, output int acc_cyc);
    acc = 1'b0;
    stalls = 0;
    acc_cyc = 0;
    @(negedge clk);
    wvalid = 1'b1;
    waddr = a;
    wdata = d;
    for (int i = 0; i < max_wait && !acc; i++) begin
      #1;
      if (wready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
        acc_cyc = cyc;
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    wvalid = 1'b0;
    $display("write addr=0x%08h data=0x%08h accepted=%0d stalls=%0d", a, d, acc, stalls);
  endtask

  task automatic idle(input int n, output int busy_hi, output int tx_lo);
    busy_hi = 0;
    tx_lo = 0;
    repeat (n) begin
      @(negedge clk);
      busy_hi += busy;
      tx_lo += !tx;
    end
  endtask

  task automatic wait_drain(input int n, input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = (rx_q.size() >= n) && !busy;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wready;
    int          nframes;
    logic [7:0]  byte_v;
    logic        finish;
    logic [15:0] code;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic        acc, ok;
    int          stalls, c0, c1, bh, tl, fstall;
    logic [7:0]  exp_q[$];
    logic [31:0] w, a;

    vecs[0] = '{ADDR,       32'h0001_0041, 1'b1, 1, 8'h41, 1'b0, 16'h0000};
    vecs[1] = '{ADDR + 4,   32'h0001_0055, 1'b1, 0, 8'h00, 1'b0, 16'h0000};
    vecs[2] = '{ADDR,       32'h0000_0055, 1'b1, 0, 8'h00, 1'b0, 16'h0000};
    vecs[3] = '{ADDR,       32'h0003_0055, 1'b1, 0, 8'h00, 1'b0, 16'h0000};
    vecs[4] = '{ADDR,       32'h0002_002A, 1'b1, 0, 8'h00, 1'b1, 16'h002A};
    vecs[5] = '{ADDR,       32'h0001_00FF, 1'b1, 1, 8'hFF, 1'b0, 16'h0000};
    vecs[6] = '{ADDR,       32'h0001_0000, 1'b1, 1, 8'h00, 1'b0, 16'h0000};
    vecs[7] = '{ADDR,       32'hFFFD_0080, 1'b1, 1, 8'h80, 1'b0, 16'h0000};

    // Reset state
    do_reset();
    #1;
    check("reset_wready", wready, 1);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_finish", finish, 0);
    check("reset_code", code, 0);

    // Single writes on an idle DUT
    for (int v = 0; v < 8; v++) begin
      do_reset();
      do_write(vecs[v].addr, vecs[v].data, 1, acc, stalls, c0);
      check($sformatf("vec%0d_wready", v), acc, vecs[v].wready);
      idle(60, bh, tl);
      check($sformatf("vec%0d_frames", v), rx_q.size(), vecs[v].nframes);
      if (rx_q.size() > 0) check($sformatf("vec%0d_byte", v), rx_q[0], vecs[v].byte_v);
      check($sformatf("vec%0d_finish", v), finish, vecs[v].finish);
      check($sformatf("vec%0d_code", v), code, vecs[v].code);
      check($sformatf("vec%0d_busy_cycles", v), bh, vecs[v].nframes * (FRAME + 1));
      check($sformatf("vec%0d_tx_idle", v), tx, 1);
    end

    // 18 back-to-back putc: the 18th write waits for the second pop
    do_reset();
    fstall = 0;
    for (int i = 0; i < 18; i++) begin
      do_write(ADDR, putc_word(8'h30 + 8'(i)), 200, acc, stalls, c0);
      if (i < 17) fstall += stalls;
      else check("fill_last_stalls", stalls, FRAME - (DEPTH - 1));
    end
    check("fill_first17_stalls", fstall, 0);
    wait_drain(18, 18 * FRAME + 200, ok);
    check("fill_drained", ok, 1);
    check("fill_frames", rx_q.size(), 18);
    for (int i = 0; i < rx_q.size(); i++) begin
      check($sformatf("fill_byte%0d", i), rx_q[i], 8'h30 + 8'(i));
      if (i > 0) check($sformatf("fill_gap%0d", i), rx_at[i] - rx_at[i-1], FRAME);
    end

    // putc then exit: finish waits for the stop bit to end
    do_reset();
    do_write(ADDR, putc_word(8'h78), 1, acc, stalls, c0);
    do_write(ADDR, exit_word(16'h0000), 1, acc, stalls, c1);
    c1 = -1;
    for (int i = 0; i < 200 && c1 < 0; i++) begin
      @(negedge clk);
      if (finish) c1 = cyc;
    end
    check("drain_finish_delay", c1 - c0, FRAME + 2);
    check("drain_code", code, 0);
    check("drain_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) check("drain_byte", rx_q[0], 8'h78);

    // exit on idle line, then a dropped putc
    do_reset();
    do_write(ADDR, exit_word(16'h002A), 1, acc, stalls, c0);
    @(negedge clk);
    check("exit_finish_early", finish, 0);
    @(negedge clk);
    check("exit_finish", finish, 1);
    check("exit_code", code, 16'h002A);
    do_write(ADDR, putc_word(8'h41), 1, acc, stalls, c0);
    check("late_putc_accepted", acc, 1);
    idle(60, bh, tl);
    check("late_putc_tx_low", tl, 0);
    check("late_putc_frames", rx_q.size(), 0);
    check("late_finish_sticky", finish, 1);

    // Reset during DATA bit 3 of the first frame
    do_reset();
    do_write(ADDR, putc_word(8'h55), 1, acc, stalls, c0);
    do_write(ADDR, putc_word(8'h66), 1, acc, stalls, c1);
    do_write(ADDR, putc_word(8'h77), 1, acc, stalls, c1);
    while (cyc < c0 + 18) @(negedge clk);
    check("midframe_tx_before", tx, 0);
    rst = 1'b1;
    #1;
    check("midframe_tx_after", tx, 1);
    check("midframe_busy_after", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(60, bh, tl);
    check("midframe_fifo_empty", bh, 0);
    check("midframe_frames", rx_q.size(), 0);
    do_write(ADDR, putc_word(8'h3C), 1, acc, stalls, c0);
    wait_drain(1, 200, ok);
    check("post_reset_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) check("post_reset_byte", rx_q[0], 8'h3C);

`ifdef TOHOST_CRLF_EN
    do_reset();
    do_write(ADDR, putc_word(8'h0A), 1, acc, stalls, c0);
    wait_drain(2, 200, ok);
    check("crlf_frames", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("crlf_cr", rx_q[0], 8'h0D);
      check("crlf_lf", rx_q[1], 8'h0A);
    end
    do_reset();
    for (int i = 0; i < 16; i++) do_write(ADDR, putc_word(8'h41), 200, acc, stalls, c0);
    do_write(ADDR, putc_word(8'h0A), 400, acc, stalls, c0);
    check("crlf_lf_stalled", stalls > 0, 1);
    check("crlf_lf_accepted", acc, 1);
    wait_drain(18, 18 * FRAME + 200, ok);
    check("crlf_full_frames", rx_q.size(), 18);
    if (rx_q.size() == 18) begin
      check("crlf_full_cr", rx_q[16], 8'h0D);
      check("crlf_full_lf", rx_q[17], 8'h0A);
    end
`endif

    // Randomized traffic against the byte-queue model
    do_reset();
    exp_q.delete();
    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        a = ADDR + 32'(4 * $urandom_range(1, 64));
        do_write(a, $urandom, 1, acc, stalls, c0);
        check("rand_nonhit_ready", acc, 1);
      end else if (kind == 1) begin
        w = $urandom;
        w[17:16] = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
        do_write(ADDR, w, 1, acc, stalls, c0);
        check("rand_nop_ready", acc, 1);
      end else begin
        w = putc_word(8'($urandom));
        do_write(ADDR, w, 4 * FRAME + 50, acc, stalls, c0);
        check("rand_putc_accepted", acc, 1);
        if (acc) begin
`ifdef TOHOST_CRLF_EN
          if (w[7:0] == 8'h0A) exp_q.push_back(8'h0D);
`endif
          exp_q.push_back(w[7:0]);
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain(exp_q.size(), exp_q.size() * FRAME + 400, ok);
    check("rand_drained", ok, 1);
    check("rand_frames", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("rand_byte%0d", i), rx_q[i], exp_q[i]);
    end
    do_write(ADDR, exit_word(16'h1234), 1, acc, stalls, c0);
    idle(4, bh, tl);
    check("rand_finish", finish, 1);
    check("rand_code", code, 16'h1234);
    check("framing_errors", frame_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
